// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_stream_1n 1:N stream demultiplexer.
package demux_pkg;

  localparam int DEMUX_DATA_W = 8;
  localparam int DEMUX_NUM_CH = 8;
  localparam int DEMUX_MAX_CH = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } demux_state_e;

  // Index beyond the widest supported channel count shifts out to an all-zero mask.
  function automatic logic [DEMUX_MAX_CH-1:0] demux_onehot(input int unsigned idx);
    return DEMUX_MAX_CH'(1) << idx;
  endfunction

  // High when a counter of the given width still has headroom for one more increment.
  function automatic logic demux_sat_step(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'(1) << width) - 64'(1));
    return (val != max_val);
  endfunction

endpackage

// File: rtl/demux_sel_decode.sv
// Select decoder: maps a channel index (or a broadcast request) to a destination
// mask and flags indices that name no existing channel.
module demux_sel_decode
  import demux_pkg::*;
#(
  parameter  int NUM_CH = DEMUX_NUM_CH,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_bcast,
  output logic [NUM_CH-1:0] o_mask,
  output logic              o_oor
);

  logic [DEMUX_MAX_CH-1:0] w_oh;
  logic                    w_above;

  assign w_oh = demux_onehot(32'(i_sel));

  // A one-hot bit landing above the channel range means the index is out of range.
  generate
    if (NUM_CH < DEMUX_MAX_CH) begin : g_range
      assign w_above = |w_oh[DEMUX_MAX_CH-1:NUM_CH];
    end else begin : g_full
      assign w_above = 1'b0;
    end
  endgenerate

  assign o_oor  = ~i_bcast & w_above;
  assign o_mask = i_bcast ? '1 : w_oh[NUM_CH-1:0];

endmodule

// File: rtl/demux_stream_1n.sv
// Registered 1:N stream demultiplexer with a one-deep output stage and per-channel
// valid/ready. Define DEMUX_BROADCAST_EN to add the s_bcast all-channel load.
module demux_stream_1n
  import demux_pkg::*;
#(
  parameter  int DATA_W = DEMUX_DATA_W,
  parameter  int NUM_CH = DEMUX_NUM_CH,
  parameter  int ERR_W  = 16,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
`ifdef DEMUX_BROADCAST_EN
  input  logic              s_bcast,
`endif
  output logic [NUM_CH-1:0] m_valid,
  input  logic [NUM_CH-1:0] m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ERR_W-1:0]  err_cnt
);

  logic [NUM_CH-1:0] r_pend;
  logic [DATA_W-1:0] r_data;
  logic [ERR_W-1:0]  r_err;

  logic [NUM_CH-1:0] w_mask;
  logic              w_oor;
  logic              w_bcast;
  logic              w_done;
  logic              w_load;
  logic              w_err_step;
  demux_state_e      w_state;

`ifdef DEMUX_BROADCAST_EN
  assign w_bcast = s_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  demux_sel_decode #(
    .NUM_CH (NUM_CH)
  ) u_dec (
    .i_sel   (s_sel),
    .i_bcast (w_bcast),
    .o_mask  (w_mask),
    .o_oor   (w_oor)
  );

  assign w_state    = (r_pend == '0) ? ST_EMPTY : ST_FULL;
  // Done once every still-pending channel is accepting on this edge.
  assign w_done     = (w_state == ST_FULL) && ((r_pend & ~m_ready) == '0);
  assign s_ready    = (w_state == ST_EMPTY) || w_done;
  assign w_load     = s_valid & s_ready;
  assign w_err_step = demux_sat_step(64'(r_err), ERR_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_data <= '0;
      r_err  <= '0;
    end else if (w_load) begin
      // A new load replaces whatever mask was released on this same edge.
      if (w_oor) begin
        r_pend <= '0;
        r_err  <= r_err + ERR_W'(w_err_step);
      end else begin
        r_pend <= w_mask;
        r_data <= s_data;
      end
    end else begin
      r_pend <= r_pend & ~m_ready;
    end
  end

  assign m_valid = r_pend;
  assign m_data  = r_data;
  assign err_cnt = r_err;

endmodule

// File: tb/tb_demux_stream_1n.sv
// Directed and randomised bench for demux_stream_1n (8-channel instance plus a
// 6-channel, 2-bit error counter instance for the out-of-range cases).
module tb_demux_stream_1n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_s_valid, a_s_ready;
  logic [7:0] a_s_data;
  logic [2:0] a_s_sel;
  logic [7:0] a_m_valid, a_m_ready, a_m_data;
  logic [15:0] a_err;

  logic       b_s_valid, b_s_ready;
  logic [7:0] b_s_data;
  logic [2:0] b_s_sel;
  logic [5:0] b_m_valid, b_m_ready;
  logic [7:0] b_m_data;
  logic [1:0] b_err;

`ifdef DEMUX_BROADCAST_EN
  logic a_s_bcast, b_s_bcast;
`endif

  demux_stream_1n #(.DATA_W(8), .NUM_CH(8), .ERR_W(16)) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .s_valid (a_s_valid),
    .s_ready (a_s_ready),
    .s_data  (a_s_data),
    .s_sel   (a_s_sel),
`ifdef DEMUX_BROADCAST_EN
    .s_bcast (a_s_bcast),
`endif
    .m_valid (a_m_valid),
    .m_ready (a_m_ready),
    .m_data  (a_m_data),
    .err_cnt (a_err)
  );

  demux_stream_1n #(.DATA_W(8), .NUM_CH(6), .ERR_W(2)) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .s_valid (b_s_valid),
    .s_ready (b_s_ready),
    .s_data  (b_s_data),
    .s_sel   (b_s_sel),
`ifdef DEMUX_BROADCAST_EN
    .s_bcast (b_s_bcast),
`endif
    .m_valid (b_m_valid),
    .m_ready (b_m_ready),
    .m_data  (b_m_data),
    .err_cnt (b_err)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } word_t;

  word_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Retire any channel accepts against the in-order scoreboard, then record a new load.
  task automatic sample_rnd(output logic pushed);
    word_t w;
    pushed = 1'b0;
    check_eq("rnd_onehot", 64'($onehot0(a_m_valid)), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (a_m_valid[i] && a_m_ready[i]) begin
        if (q.size() == 0) begin
          check_eq("rnd_extra_ch", 64'(i), 64'hDEAD);
        end else begin
          w = q.pop_front();
          check_eq("rnd_ch", 64'(i), 64'(w.sel));
          check_eq("rnd_data", 64'(a_m_data), 64'(w.data));
        end
      end
    end
    if (a_s_valid && a_s_ready) begin
      w.sel  = a_s_sel;
      w.data = a_s_data;
      q.push_back(w);
      pushed = 1'b1;
    end
  endtask

  initial begin
    int   words;
    int   cycles;
    logic pushed;

    rst = 1'b1;
    a_s_valid = 1'b0; a_s_data = '0; a_s_sel = '0; a_m_ready = '0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_sel = '0; b_m_ready = '0;
`ifdef DEMUX_BROADCAST_EN
    a_s_bcast = 1'b0; b_s_bcast = 1'b0;
`endif
    step();
    step();
    check_eq("rst_m_valid", 64'(a_m_valid), 64'h00);
    check_eq("rst_m_data", 64'(a_m_data), 64'h00);
    check_eq("rst_err", 64'(a_err), 64'h0);
    check_eq("rst_s_ready", 64'(a_s_ready), 64'h1);
    rst = 1'b0;

    // Reset while a word is held
    a_s_valid = 1'b1; a_s_data = 8'h77; a_s_sel = 3'd2; a_m_ready = 8'h00;
    #1 check_eq("empty_s_ready", 64'(a_s_ready), 64'h1);
    step();
    a_s_valid = 1'b0;
    #1 check_eq("held_m_valid", 64'(a_m_valid), 64'h04);
    check_eq("held_m_data", 64'(a_m_data), 64'h77);
    #1 rst = 1'b1;
    #1 check_eq("arst_m_valid", 64'(a_m_valid), 64'h00);
    check_eq("arst_m_data", 64'(a_m_data), 64'h00);
    check_eq("arst_err", 64'(a_err), 64'h0);
    #1 rst = 1'b0;

    // Unicast streaming with all consumers ready
    a_m_ready = 8'hFF;
    a_s_valid = 1'b1; a_s_data = 8'hA1; a_s_sel = 3'd3;
    step();
    a_s_data = 8'hB2; a_s_sel = 3'd5;
    #1 check_eq("uni1_m_valid", 64'(a_m_valid), 64'h08);
    check_eq("uni1_m_data", 64'(a_m_data), 64'hA1);
    check_eq("uni1_s_ready", 64'(a_s_ready), 64'h1);
    step();
    a_s_valid = 1'b0;
    #1 check_eq("uni2_m_valid", 64'(a_m_valid), 64'h20);
    check_eq("uni2_m_data", 64'(a_m_data), 64'hB2);
    check_eq("uni2_s_ready", 64'(a_s_ready), 64'h1);
    step();
    #1 check_eq("uni3_m_valid", 64'(a_m_valid), 64'h00);

    // Backpressure on channel 2 while other ready bits toggle
    a_m_ready = 8'hFB;
    a_s_valid = 1'b1; a_s_data = 8'h3C; a_s_sel = 3'd2;
    step();
    a_s_data = 8'h4D; a_s_sel = 3'd6;
    for (int k = 0; k < 4; k++) begin
      a_m_ready = (k % 2 == 0) ? 8'hFB : 8'h00;
      #1 check_eq("bp_m_valid", 64'(a_m_valid), 64'h04);
      check_eq("bp_m_data", 64'(a_m_data), 64'h3C);
      check_eq("bp_s_ready", 64'(a_s_ready), 64'h0);
      step();
    end
    a_m_ready = 8'hFF;
    #1 check_eq("bp_release_s_ready", 64'(a_s_ready), 64'h1);
    step();
    a_s_valid = 1'b0;
    #1 check_eq("bp_next_m_valid", 64'(a_m_valid), 64'h40);
    check_eq("bp_next_m_data", 64'(a_m_data), 64'h4D);
    step();
    #1 check_eq("bp_drain_m_valid", 64'(a_m_valid), 64'h00);

    // Out-of-range selects on the 6-channel instance
    b_m_ready = 6'h3F;
    b_s_valid = 1'b1; b_s_sel = 3'd7; b_s_data = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("oor_s_ready", 64'(b_s_ready), 64'h1);
      step();
    end
    b_s_valid = 1'b0;
    #1 check_eq("oor_m_valid", 64'(b_m_valid), 64'h00);
    check_eq("oor_m_data", 64'(b_m_data), 64'h00);
    check_eq("oor_err3", 64'(b_err), 64'h3);
    b_s_valid = 1'b1;
    step();
    step();
    b_s_valid = 1'b0;
    #1 check_eq("oor_err_sat", 64'(b_err), 64'h3);
    b_s_valid = 1'b1; b_s_sel = 3'd5; b_s_data = 8'h99; b_m_ready = 6'h00;
    step();
    b_s_sel = 3'd6; b_s_data = 8'h11; b_m_ready = 6'h3F;
    #1 check_eq("oor_ld_m_valid", 64'(b_m_valid), 64'h20);
    check_eq("oor_ld_m_data", 64'(b_m_data), 64'h99);
    check_eq("oor_ld_s_ready", 64'(b_s_ready), 64'h1);
    step();
    b_s_valid = 1'b0;
    #1 check_eq("oor6_m_valid", 64'(b_m_valid), 64'h00);
    check_eq("oor6_m_data", 64'(b_m_data), 64'h99);
    check_eq("oor6_err", 64'(b_err), 64'h3);

`ifdef DEMUX_BROADCAST_EN
    // Broadcast load drained in two halves
    a_m_ready = 8'h0F;
    a_s_valid = 1'b1; a_s_bcast = 1'b1; a_s_data = 8'h5C; a_s_sel = 3'd0;
    step();
    a_s_valid = 1'b0; a_s_bcast = 1'b0;
    #1 check_eq("bc1_m_valid", 64'(a_m_valid), 64'hFF);
    check_eq("bc1_m_data", 64'(a_m_data), 64'h5C);
    check_eq("bc1_s_ready", 64'(a_s_ready), 64'h0);
    step();
    a_m_ready = 8'hF0;
    #1 check_eq("bc2_m_valid", 64'(a_m_valid), 64'hF0);
    check_eq("bc2_s_ready", 64'(a_s_ready), 64'h1);
    step();
    #1 check_eq("bc3_m_valid", 64'(a_m_valid), 64'h00);
`endif

    // Randomised traffic against an in-order scoreboard
    words  = 0;
    cycles = 0;
    while (words < 10000 && cycles < 80000) begin
      step();
      a_s_valid = ($urandom_range(3) != 0);
      a_s_sel   = 3'($urandom_range(7));
      a_s_data  = 8'($urandom);
      a_m_ready = 8'($urandom);
      #1 sample_rnd(pushed);
      if (pushed) words++;
      cycles++;
    end
    check_eq("rnd_words", 64'(words), 64'd10000);
    step();
    a_s_valid = 1'b0;
    a_m_ready = 8'hFF;
    #1 sample_rnd(pushed);
    step();
    #1 check_eq("rnd_drain_m_valid", 64'(a_m_valid), 64'h00);
    check_eq("rnd_drain_queue", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
